// File: rtl/conv_window_feeder.sv
// Sliding-window feeder: shifts incoming image columns into a KERNEL_WIDTH-wide window
// and hands off one window per STRIDE columns over a single-entry valid/ready output.
module conv_window_feeder #(
    parameter int DATA_WIDTH    = 8,
    parameter int PARALLEL_IFM  = 2,
    parameter int KERNEL_WIDTH  = 3,
    parameter int KERNEL_HEIGHT = 3,
    parameter int ROW_WIDTH     = 5,
    parameter int STRIDE        = 1
) (
    input  logic                                                          clk,
    input  logic                                                          srst,
    input  logic                                                          start,
    input  logic                                                          flush,
    input  logic [PARALLEL_IFM-1:0]                                       pifm_active,
    input  logic                                                          in_valid,
    output logic                                                          in_ready,
    input  logic [PARALLEL_IFM-1:0][KERNEL_HEIGHT-1:0][DATA_WIDTH-1:0]    in_col,
    output logic                                                          out_valid,
    input  logic                                                          out_ready,
    output logic [PARALLEL_IFM-1:0][KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][DATA_WIDTH-1:0] out_win,
    output logic [$clog2(ROW_WIDTH+1)-1:0]                                win_cnt,
    output logic                                                          busy,
    output logic                                                          done
);

    if (KERNEL_WIDTH > ROW_WIDTH || STRIDE < 1 || DATA_WIDTH < 1 || PARALLEL_IFM < 1 ||
        KERNEL_WIDTH < 1 || KERNEL_HEIGHT < 1 || ROW_WIDTH < 1) begin : g_bad_params
        $error("conv_window_feeder: illegal parameter combination");
    end

    localparam int CntW = $clog2(ROW_WIDTH + 1);
    localparam int PhW  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CntW-1:0] LastCol  = CntW'(ROW_WIDTH - 1);
    localparam logic [CntW-1:0] FirstWin = CntW'(KERNEL_WIDTH - 1);
    localparam logic [PhW-1:0]  PhLast   = PhW'(STRIDE - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StFin} state_e;

    typedef logic [PARALLEL_IFM-1:0][KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][DATA_WIDTH-1:0] win_t;

    state_e          state_q, state_d;
    logic [CntW-1:0] col_q, col_d;
    logic [PhW-1:0]  phase_q, phase_d;
    logic [CntW-1:0] win_cnt_q, win_cnt_d;
    logic            out_valid_q, out_valid_d;
    win_t            win_q, win_d;
    logic            emit;

    // phase_q counts columns since the last emitted window once the first full window exists
    assign emit = (col_q >= FirstWin) && (phase_q == '0);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        phase_d     = phase_q;
        win_cnt_d   = win_cnt_q;
        out_valid_d = out_valid_q;
        win_d       = win_q;
        in_ready    = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            win_cnt_d   = win_cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StLoad;
                    col_d     = '0;
                    phase_d   = '0;
                    win_cnt_d = '0;
                    win_d     = '0;
                end
            end
            StLoad: begin
                in_ready = !out_valid_q || out_ready;
                if (in_valid && in_ready) begin
                    for (int c = 0; c < PARALLEL_IFM; c++) begin
                        for (int h = 0; h < KERNEL_HEIGHT; h++) begin
                            for (int k = 0; k < KERNEL_WIDTH - 1; k++) begin
                                win_d[c][h][k] = win_q[c][h][k+1];
                            end
                            win_d[c][h][KERNEL_WIDTH-1] = pifm_active[c] ? in_col[c][h] : '0;
                        end
                    end
                    col_d       = col_q + CntW'(1);
                    out_valid_d = emit;
                    if (col_q >= FirstWin) begin
                        phase_d = (phase_q == PhLast) ? '0 : phase_q + PhW'(1);
                    end
                    if (col_q == LastCol) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!out_valid_q) begin
                    state_d = StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Abort discards the pending window and any handshake of this cycle
        if (flush) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            col_d       = '0;
            phase_d     = '0;
            win_cnt_d   = win_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= StIdle;
            col_q       <= '0;
            phase_q     <= '0;
            win_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            phase_q     <= phase_d;
            win_cnt_q   <= win_cnt_d;
            out_valid_q <= out_valid_d;
            win_q       <= win_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_win   = win_q;
    assign win_cnt   = win_cnt_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StFin);

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: directed rows on a default instance and a stride-2 instance,
// with a queue-based scoreboard checking every window handed off.
module tb_conv_window_feeder;

    typedef logic [1:0][2:0][7:0]       col_t;
    typedef logic [1:0][2:0][2:0][7:0]  win_t;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    win_t qa[$];
    win_t qb[$];

    logic       a_start, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy, a_done;
    logic [1:0] a_pifm;
    col_t       a_in_col;
    win_t       a_out_win;
    logic [2:0] a_win_cnt;

    logic       b_start, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_done;
    logic [1:0] b_pifm;
    col_t       b_in_col;
    win_t       b_out_win;
    logic [2:0] b_win_cnt;

    conv_window_feeder dut_a (
        .clk(clk), .srst(srst), .start(a_start), .flush(a_flush), .pifm_active(a_pifm),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_col(a_in_col),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_win(a_out_win),
        .win_cnt(a_win_cnt), .busy(a_busy), .done(a_done)
    );

    conv_window_feeder #(.ROW_WIDTH(7), .STRIDE(2)) dut_b (
        .clk(clk), .srst(srst), .start(b_start), .flush(b_flush), .pifm_active(b_pifm),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_col(b_in_col),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_win(b_out_win),
        .win_cnt(b_win_cnt), .busy(b_busy), .done(b_done)
    );

    // Pixel value encodes column, channel and row so swaps are visible
    function automatic logic [7:0] pix(int v, int c, int h);
        return 8'(v + 16 * c + 64 * h);
    endfunction

    function automatic col_t mk_col(int v);
        col_t r;
        for (int c = 0; c < 2; c++)
            for (int h = 0; h < 3; h++) r[c][h] = pix(v, c, h);
        return r;
    endfunction

    function automatic win_t mk_win(int first, logic [1:0] act);
        win_t r;
        for (int c = 0; c < 2; c++)
            for (int h = 0; h < 3; h++)
                for (int k = 0; k < 3; k++) r[c][h][k] = act[c] ? pix(first + k, c, h) : 8'd0;
        return r;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
            if (qa.size() == 0) chk("a_extra_window", a_out_valid, 1'b0);
            else chk("a_window", a_out_win, qa.pop_front());
        end
        if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
            if (qb.size() == 0) chk("b_extra_window", b_out_valid, 1'b0);
            else chk("b_window", b_out_win, qb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(int v, bit push, logic [1:0] act);
        int n = 0;
        a_in_valid = 1'b1;
        a_in_col   = mk_col(v);
        while (!a_in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("a_send_timeout", a_in_ready, 1'b1);
        if (push) qa.push_back(mk_win(v - 2, act));
        step();
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(int v, bit push);
        int n = 0;
        b_in_valid = 1'b1;
        b_in_col   = mk_col(v);
        while (!b_in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("b_send_timeout", b_in_ready, 1'b1);
        if (push) qb.push_back(mk_win(v - 2, 2'b11));
        step();
        b_in_valid = 1'b0;
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (a_done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("a_done_seen", a_done, 1'b1);
    endtask

    task automatic start_a();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        srst = 1'b1;
        a_start = 0; a_flush = 0; a_in_valid = 0; a_out_ready = 1; a_pifm = 2'b11;
        a_in_col = '0;
        b_start = 0; b_flush = 0; b_in_valid = 0; b_out_ready = 1; b_pifm = 2'b11;
        b_in_col = '0;
        step();
        step();
        chk("rst_in_ready", a_in_ready, 1'b0);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_win", a_out_win, '0);
        chk("rst_win_cnt", a_win_cnt, 3'd0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_done", a_done, 1'b0);
        srst = 1'b0;
        step();

        // Basic row, back-to-back columns
        start_a();
        chk("t1_busy", a_busy, 1'b1);
        chk("t1_in_ready", a_in_ready, 1'b1);
        send_a(1, 0, 2'b11);
        send_a(2, 0, 2'b11);
        chk("t1_no_early_valid", a_out_valid, 1'b0);
        send_a(3, 1, 2'b11);
        chk("t1_latency", a_out_valid, 1'b1);
        send_a(4, 1, 2'b11);
        chk("t1_consec4", a_out_valid, 1'b1);
        send_a(5, 1, 2'b11);
        chk("t1_consec5", a_out_valid, 1'b1);
        chk("t1_drain_ready", a_in_ready, 1'b0);
        step();
        chk("t1_drain_valid", a_out_valid, 1'b0);
        chk("t1_drain_done", a_done, 1'b0);
        step();
        chk("t1_fin_done", a_done, 1'b1);
        chk("t1_win_cnt", a_win_cnt, 3'd3);
        step();
        chk("t1_done_pulse", a_done, 1'b0);
        chk("t1_idle", a_busy, 1'b0);
        chk("t1_cnt_hold", a_win_cnt, 3'd3);

        // Backpressure with channel 1 disabled
        a_pifm = 2'b01;
        start_a();
        chk("t2_cnt_cleared", a_win_cnt, 3'd0);
        send_a(1, 0, 2'b01);
        send_a(2, 0, 2'b01);
        a_out_ready = 1'b0;
        send_a(3, 1, 2'b01);
        a_in_valid = 1'b1;
        a_in_col   = mk_col(4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_stall_valid", a_out_valid, 1'b1);
            chk("t2_stall_ready", a_in_ready, 1'b0);
            chk("t2_stall_win", a_out_win, mk_win(1, 2'b01));
            step();
        end
        a_out_ready = 1'b1;
        qa.push_back(mk_win(2, 2'b01));
        step();
        a_in_valid = 1'b0;
        chk("t2_resume_valid", a_out_valid, 1'b1);
        chk("t2_resume_win", a_out_win, mk_win(2, 2'b01));
        send_a(5, 1, 2'b01);
        wait_done_a();
        chk("t2_win_cnt", a_win_cnt, 3'd3);
        step();
        a_pifm = 2'b11;

        // Flush mid-row, flush beats a simultaneous start
        start_a();
        send_a(1, 0, 2'b11);
        send_a(2, 0, 2'b11);
        a_flush = 1'b1;
        a_start = 1'b1;
        step();
        a_flush = 1'b0;
        a_start = 1'b0;
        chk("t3_flush_busy", a_busy, 1'b0);
        chk("t3_flush_valid", a_out_valid, 1'b0);
        chk("t3_flush_ready", a_in_ready, 1'b0);
        chk("t3_flush_done", a_done, 1'b0);
        step();
        chk("t3_flush_done2", a_done, 1'b0);
        start_a();
        for (int v = 1; v <= 5; v++) send_a(v, v >= 3, 2'b11);
        wait_done_a();
        chk("t3_win_cnt", a_win_cnt, 3'd3);
        step();

        // Reset mid-row with a window pending; start under reset is ignored
        start_a();
        for (int v = 1; v <= 4; v++) send_a(v, v >= 3, 2'b11);
        chk("t4_pending", a_out_valid, 1'b1);
        srst = 1'b1;
        a_start = 1'b1;
        step();
        chk("t4_in_ready", a_in_ready, 1'b0);
        chk("t4_out_valid", a_out_valid, 1'b0);
        chk("t4_out_win", a_out_win, '0);
        chk("t4_win_cnt", a_win_cnt, 3'd0);
        chk("t4_busy", a_busy, 1'b0);
        chk("t4_done", a_done, 1'b0);
        step();
        chk("t4_start_ignored", a_busy, 1'b0);
        srst = 1'b0;
        a_start = 1'b0;
        step();
        chk("t4_no_done", a_done, 1'b0);

        // Stride 2 over a 7-column row
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int v = 1; v <= 7; v++) begin
            send_b(v, (v >= 3) && (v % 2 == 1));
            if (v == 3) chk("b_first_valid", b_out_valid, 1'b1);
            if (v == 4) chk("b_absorbed", b_out_valid, 1'b0);
        end
        begin
            int n = 0;
            while (b_done !== 1'b1 && n < 20) begin
                step();
                n++;
            end
        end
        chk("b_done_seen", b_done, 1'b1);
        chk("b_win_cnt", b_win_cnt, 3'd3);

        step();
        step();
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL provide parameter PARALLEL_IFM, default 2, number of input-feature-map channels.
REQ-003 SHALL provide parameter KERNEL_WIDTH, default 3, window columns.
REQ-004 SHALL provide parameter KERNEL_HEIGHT, default 3, window rows and pixels per input column.
REQ-005 SHALL provide parameter ROW_WIDTH, default 5, columns per image row.
REQ-006 SHALL provide parameter STRIDE, default 1, horizontal column step between emitted windows.
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; srst  input  1  synchronous active-high reset.
REQ-008 SHALL have start  input  1  begins one row when idle.
REQ-009 SHALL have flush  input  1  aborts the current row.
REQ-010 SHALL have pifm_active  input  PARALLEL_IFM x 1  per-channel enable.
REQ-011 SHALL have in_valid  input  1; in_ready  output  1; in_col  input  PARALLEL_IFM x KERNEL_HEIGHT x DATA_WIDTH  one column per channel.
REQ-012 SHALL have out_valid  output  1; out_ready  input  1; out_win  output  PARALLEL_IFM x KERNEL_HEIGHT x KERNEL_WIDTH x DATA_WIDTH  window, index KERNEL_WIDTH-1 newest column.
REQ-013 SHALL have win_cnt  output  $clog2(ROW_WIDTH+1)  windows handed off in current row; busy  output  1  state not IDLE; done  output  1  one-cycle end-of-row pulse.

Function
REQ-014 SHALL fail elaboration if KERNEL_WIDTH > ROW_WIDTH, STRIDE < 1 or any size parameter < 1.
REQ-015 SHALL implement states IDLE, LOAD, DRAIN, FIN.
REQ-016 IDLE: in_ready=0; start (without flush) -> LOAD, column counter=0, window registers cleared, win_cnt=0; start outside IDLE ignored.
REQ-017 LOAD: in_ready = !out_valid || out_ready; an input transfer occurs when in_valid && in_ready.
REQ-018 On each transfer the window shifts one column toward index 0, in_col enters index KERNEL_WIDTH-1, and the column counter increments.
REQ-019 A transfer of column index i SHALL set out_valid the next cycle iff i >= KERNEL_WIDTH-1 and (i-(KERNEL_WIDTH-1)) mod STRIDE == 0; columns failing this rule are absorbed without output.
REQ-020 out_win and out_valid SHALL hold stable while out_valid && !out_ready; out_valid clears after handshake unless a new window is loaded in the same cycle.
REQ-021 Channels with pifm_active=0 SHALL present all-zero pixels on out_win, sampled at the input transfer.
REQ-022 win_cnt SHALL increment on each out_valid && out_ready handshake; the row total is (ROW_WIDTH-KERNEL_WIDTH)/STRIDE+1 (integer division).
REQ-023 Transfer of column ROW_WIDTH-1 -> DRAIN; DRAIN holds in_ready=0 until out_valid=0, then -> FIN.
REQ-024 FIN SHALL assert done for exactly one cycle, then -> IDLE; win_cnt holds until the next start.
REQ-025 flush in any state SHALL, next cycle, force IDLE, out_valid=0, column counter=0, with no done pulse; flush wins over simultaneous start, transfer or handshake.
REQ-026 Latency: input transfer to out_valid is exactly one cycle; at most one window is buffered (no skid).

Reset
REQ-027 srst SHALL take priority over all inputs and, on the next edge, set state=IDLE, in_ready=0, out_valid=0, out_win=0, win_cnt=0, busy=0, done=0, column counter=0.
REQ-028 srst asserted mid-row SHALL discard the partial row without a done pulse.

Verification
REQ-029 Defaults, out_ready=1, columns valued 1..5 (all pixels = column value) streamed back-to-back -> windows {1,2,3},{2,3,4},{3,4,5} on consecutive cycles, first one cycle after the 3rd transfer; win_cnt=3; done one cycle after leaving DRAIN.
REQ-030 ROW_WIDTH=7, STRIDE=2, columns 1..7 -> exactly windows {1,2,3},{3,4,5},{5,6,7}; win_cnt=3.
REQ-031 out_ready=0 for 4 cycles while a window is pending -> out_win unchanged, in_ready=0; out_ready=1 -> handshake, streaming resumes with no lost column.
REQ-032 pifm_active={1,0} -> channel 1 pixels in out_win all 0, channel 0 correct.
REQ-033 flush after the 2nd column -> next cycle IDLE, out_valid=0, no done; a subsequent start produces a correct full row.
REQ-034 srst after the 4th column with out_valid=1 -> all outputs reset next cycle, no done; start in IDLE with srst high is ignored.
